// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB-first, optional
// parity bit, one stop bit. Each bit lasts Prescale clock cycles. The frame
// settings are captured when a word is accepted, so the host may change its
// inputs freely while a frame is on the line.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int IDX_W = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                  state_reg,  state_next;
    logic [5:0]              cnt_reg,    cnt_next;
    logic [IDX_W-1:0]        idx_reg,    idx_next;
    logic [DATA_WIDTH-1:0]   data_reg,   data_next;
    logic                    par_en_reg, par_en_next;
    logic                    parity_reg, parity_next;
    logic [5:0]              presc_reg,  presc_next;
    logic                    tx_reg,     tx_next;
    logic                    busy_reg,   busy_next;

    logic                    bit_end;
    logic [DATA_WIDTH-1:0]   par_chain;

    // Running XOR across the incoming word; the last tap is the even parity.
    assign par_chain[0] = P_DATA[0];
    generate
        for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_par
            assign par_chain[gi] = par_chain[gi-1] ^ P_DATA[gi];
        end
    endgenerate

    // The last cycle of the current bit period.
    assign bit_end = (cnt_reg == presc_reg - 6'd1);

    // The serial line and Busy come straight from flops, so the pad never sees
    // a combinational glitch.
    assign TX_OUT = tx_reg;
    assign Busy   = busy_reg;

    // State and datapath registers; reset aborts any frame in progress.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            data_reg   <= '0;
            par_en_reg <= 1'b0;
            parity_reg <= 1'b0;
            presc_reg  <= '0;
            tx_reg     <= 1'b1;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            data_reg   <= data_next;
            par_en_reg <= par_en_next;
            parity_reg <= parity_next;
            presc_reg  <= presc_next;
            tx_reg     <= tx_next;
            busy_reg   <= busy_next;
        end
    end

    // Next-state logic; the outputs are decoded from the *next* state so the
    // registered line changes on the same edge as the state.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        data_next   = data_reg;
        par_en_next = par_en_reg;
        parity_next = parity_reg;
        presc_next  = presc_reg;
        tx_next     = 1'b1;
        busy_next   = 1'b0;

        if (state_reg == IDLE) begin
            cnt_next = '0;
            idx_next = '0;
            if (Data_Valid) begin
                state_next  = START;
                data_next   = P_DATA;
                par_en_next = PAR_EN;
                parity_next = par_chain[DATA_WIDTH-1] ^ PAR_TYP;
                presc_next  = (Prescale == 6'd0) ? 6'd1 : Prescale;
            end
        end else if (!bit_end) begin
            cnt_next = cnt_reg + 6'd1;
        end else begin
            cnt_next = '0;
            case (state_reg)
                START: begin
                    state_next = DATA;
                    idx_next   = '0;
                end
                DATA: begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next   = '0;
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        idx_next = idx_reg + IDX_W'(1);
                    end
                end
                PARITY:  state_next = STOP;
                STOP:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        case (state_next)
            IDLE: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
            START: begin
                tx_next   = 1'b0;
                busy_next = 1'b1;
            end
            DATA: begin
                tx_next   = data_next[idx_next];
                busy_next = 1'b1;
            end
            PARITY: begin
                tx_next   = parity_next;
                busy_next = 1'b1;
            end
            STOP: begin
                tx_next   = 1'b1;
                busy_next = 1'b1;
            end
            default: begin
                tx_next   = 1'b1;
                busy_next = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmitter; the transmit-side counterpart of the receive path and its start-bit checker.
- Serializes one parallel data word per frame on a single line: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit (1).
- Bit timing comes from a prescale counter running on CLK, so one bit lasts Prescale CLK cycles. This matches the receiver's oversampling clock domain.
- Sits between the host-side data source (valid/busy handshake) and the serial pad.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (legal 5..9).

Ports:
- CLK  input  1  clock; the oversampling clock shared with the receiver.
- RST  input  1  synchronous, active-low reset.
- P_DATA  input  DATA_WIDTH  parallel word to transmit.
- Data_Valid  input  1  request to send P_DATA; honoured only when Busy=0.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- Prescale  input  6  CLK cycles per bit; legal values 1..63; a value of 0 is treated as 1.
- TX_OUT  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=0 at a CLK edge): state=IDLE, TX_OUT=1, Busy=0; all internal counters and registers clear. Reset mid-frame aborts the frame immediately; nothing is resumed.
- All outputs are registered.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a CLK edge, the following are latched together: P_DATA, PAR_EN, PAR_TYP, Prescale, and parity.
  - Parity = XOR-reduce(P_DATA) for even; its inverse for odd.
  - Next state is START. TX_OUT falls to 0 and Busy rises to 1 in the cycle after the accepting edge (1-cycle latency).
- Input changes after acceptance have no effect on the current frame.
- Bit counter: counts 0..Prescale-1 within each bit. Each state holds for exactly Prescale cycles, then advances.
- START: TX_OUT=0 → DATA.
- DATA: TX_OUT = latched bit[idx], idx 0..DATA_WIDTH-1.
  - idx increments at each bit boundary.
  - After the last bit, go to PARITY if PAR_EN was latched as 1, else STOP.
- PARITY: TX_OUT = latched parity → STOP.
- STOP: TX_OUT=1, Busy=1 → IDLE.
- Frame length: (2 + DATA_WIDTH + PAR_EN) × Prescale cycles, measured from the first TX_OUT=0 cycle to the last stop-bit cycle.
- Handshake:
  - Data_Valid while Busy=1 (including during STOP) is ignored, not queued.
  - Minimum inter-frame gap: 1 IDLE cycle with TX_OUT=1 and Busy=0. If Data_Valid is held high, the next frame starts immediately after that cycle.
- TX_OUT must be glitch-free: driven straight from a register, with no combinational output path.

Test Plan:
- Reset, then hold Data_Valid=0 for 20 cycles -> TX_OUT=1 and Busy=0 throughout.
- Prescale=8, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, Data_Valid pulsed 1 cycle -> bit sequence 0,1,0,1,0,0,1,0,1,0,1 with each bit held 8 cycles. Busy=1 for exactly 88 cycles, and TX_OUT falls 1 cycle after the accepting edge.
- Same as above but PAR_TYP=1 -> parity bit=1; every other bit unchanged.
- Prescale=16, PAR_EN=0, P_DATA=0xFF -> frame 0, eight 1s, 1, each bit 16 cycles, 160 cycles total. While Busy=1, change P_DATA to 0x00 and pulse Data_Valid -> frame unchanged and no second frame.
- Hold Data_Valid=1 continuously, P_DATA=0x3C, Prescale=1, PAR_EN=0 -> back-to-back 10-cycle frames separated by exactly 1 idle cycle with TX_OUT=1 and Busy=0.
- Prescale=8; assert RST=0 during the 4th data bit -> next cycle TX_OUT=1, Busy=0, state IDLE. A new Data_Valid after release sends a complete, correct frame.
